// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, requester ids and the forward S-box.
package aes_pkg;

    localparam int unsigned WORD = 32;
    localparam int unsigned NB   = 4;

    typedef enum logic {
        R0 = 1'b0,
        R1 = 1'b1
    } req_id_e;

    // Forward S-box, entry k at index k (index 0 is the leftmost byte).
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/subbytes_arb_subbytes.sv
// Combinational SubBytes over a whole block: every byte passes through the S-box.
module subbytes_arb_subbytes
    import aes_pkg::*;
#(
    parameter int unsigned WIDTH = aes_pkg::WORD * aes_pkg::NB
) (
    input  logic [WIDTH-1:0] block_i,
    output logic [WIDTH-1:0] block_c_o
);

    localparam int unsigned NBYTES = WIDTH / 8;

    if ((WIDTH % 8) != 0) begin : g_width_check
        $error("subbytes_arb_subbytes: WIDTH must be a whole number of bytes");
    end

    always_comb begin
        block_c_o = '0;
        for (int i = 0; i < NBYTES; i++) begin
            block_c_o[8*i +: 8] = sbox_byte(block_i[8*i +: 8]);
        end
    end

endmodule

// File: rtl/subbytes_arb.sv
// Two-requester arbiter sharing one SubBytes stage; requester 0 may lock a bounded burst.
module subbytes_arb
    import aes_pkg::*;
#(
    parameter int unsigned WORD     = aes_pkg::WORD,
    parameter int unsigned NB       = aes_pkg::NB,
    parameter int unsigned LOCK_MAX = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r0_valid,
    input  logic                 r0_lock,
    input  logic [WORD*NB-1:0]   r0_block,
    output logic                 r0_ready,
    input  logic                 r1_valid,
    input  logic [WORD*NB-1:0]   r1_block,
    output logic                 r1_ready,
    output logic                 r0_o_valid,
    output logic [WORD*NB-1:0]   r0_o_block,
    output logic                 r1_o_valid,
    output logic [WORD*NB-1:0]   r1_o_block
);

    localparam int unsigned BW = WORD * NB;
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    // Arbiter state: rr_q set means requester 1 wins the next tie.
    logic          rr_q,        rr_d;
    logic          prev0_q,     prev0_d;
    logic [CW-1:0] lock_cnt_q,  lock_cnt_d;

    // SubBytes input stage with the routing tag.
    logic          s1_valid_q,  s1_valid_d;
    req_id_e       s1_tag_q,    s1_tag_d;
    logic [BW-1:0] s1_block_q,  s1_block_d;

    logic          r0_o_valid_q, r0_o_valid_d;
    logic [BW-1:0] r0_o_block_q, r0_o_block_d;
    logic          r1_o_valid_q, r1_o_valid_d;
    logic [BW-1:0] r1_o_block_q, r1_o_block_d;

    logic          lock_hold_c;
    logic          gnt0_c;
    logic          gnt1_c;
    logic [BW-1:0] sub_c;

    subbytes_arb_subbytes #(
        .WIDTH (BW)
    ) u_subbytes (
        .block_i   (s1_block_q),
        .block_c_o (sub_c)
    );

    // Grant decision: lock beats round-robin, a lone valid always wins.
    always_comb begin
        lock_hold_c = prev0_q & r0_lock & r0_valid & (lock_cnt_q < CW'(LOCK_MAX));
        gnt0_c      = rst & r0_valid & (lock_hold_c | ~r1_valid | ~rr_q);
        gnt1_c      = rst & r1_valid & ~gnt0_c;
    end

    assign r0_ready = gnt0_c;
    assign r1_ready = gnt1_c;

    always_comb begin
        rr_d         = rr_q;
        prev0_d      = gnt0_c;
        lock_cnt_d   = '0;
        s1_valid_d   = gnt0_c | gnt1_c;
        s1_tag_d     = s1_tag_q;
        s1_block_d   = s1_block_q;
        r0_o_valid_d = 1'b0;
        r0_o_block_d = r0_o_block_q;
        r1_o_valid_d = 1'b0;
        r1_o_block_d = r1_o_block_q;

        if (gnt0_c) begin
            rr_d       = 1'b1;
            s1_tag_d   = R0;
            s1_block_d = r0_block;
        end else if (gnt1_c) begin
            rr_d       = 1'b0;
            s1_tag_d   = R1;
            s1_block_d = r1_block;
        end

        // Count back-to-back locked grants, saturating at the limit.
        if (gnt0_c && r0_lock && prev0_q) begin
            if (lock_cnt_q == CW'(LOCK_MAX)) begin
                lock_cnt_d = lock_cnt_q;
            end else begin
                lock_cnt_d = lock_cnt_q + CW'(1);
            end
        end

        if (s1_valid_q) begin
            if (s1_tag_q == R0) begin
                r0_o_valid_d = 1'b1;
                r0_o_block_d = sub_c;
            end else begin
                r1_o_valid_d = 1'b1;
                r1_o_block_d = sub_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q         <= 1'b0;
            prev0_q      <= 1'b0;
            lock_cnt_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_tag_q     <= R0;
            s1_block_q   <= '0;
            r0_o_valid_q <= 1'b0;
            r0_o_block_q <= '0;
            r1_o_valid_q <= 1'b0;
            r1_o_block_q <= '0;
        end else begin
            rr_q         <= rr_d;
            prev0_q      <= prev0_d;
            lock_cnt_q   <= lock_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_tag_q     <= s1_tag_d;
            s1_block_q   <= s1_block_d;
            r0_o_valid_q <= r0_o_valid_d;
            r0_o_block_q <= r0_o_block_d;
            r1_o_valid_q <= r1_o_valid_d;
            r1_o_block_q <= r1_o_block_d;
        end
    end

    assign r0_o_valid = r0_o_valid_q;
    assign r0_o_block = r0_o_block_q;
    assign r1_o_valid = r1_o_valid_q;
    assign r1_o_block = r1_o_block_q;

endmodule

// File: tb/tb_subbytes_arb.sv
// Randomized bench for subbytes_arb against a rule-level arbiter model and a GF(2^8) S-box.
module tb_subbytes_arb;

    localparam int unsigned WORD     = 32;
    localparam int unsigned NB       = 4;
    localparam int unsigned LOCK_MAX = 10;
    localparam int unsigned BW       = WORD * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_lock, r1_valid;
    logic [BW-1:0] r0_block, r1_block;
    logic          r0_ready, r1_ready;
    logic          r0_o_valid, r1_o_valid;
    logic [BW-1:0] r0_o_block, r1_o_block;

    always #5 clk = ~clk;

    subbytes_arb #(
        .WORD     (WORD),
        .NB       (NB),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_valid   (r0_valid),
        .r0_lock    (r0_lock),
        .r0_block   (r0_block),
        .r0_ready   (r0_ready),
        .r1_valid   (r1_valid),
        .r1_block   (r1_block),
        .r1_ready   (r1_ready),
        .r0_o_valid (r0_o_valid),
        .r0_o_block (r0_o_block),
        .r1_o_valid (r1_o_valid),
        .r1_o_block (r1_o_block)
    );

    typedef struct {
        bit            who;
        logic [BW-1:0] blk;
        int            due;
    } item_t;

    item_t         sb[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            last_win;      // -1: nobody granted since reset
    bit            prev0;
    int            streak;        // locked grants in the current r0 run
    logic [BW-1:0] hold0, hold1;
    bit            obs_g0, obs_g1;
    logic [7:0]    sref [256];

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] a);
        logic [7:0] inv, r;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        r = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
              ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
        return r;
    endfunction

    function automatic logic [BW-1:0] sub_block(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(BW / 8); i++) r[8*i +: 8] = sref[b[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] r;
        for (int i = 0; i < int'(BW / 32); i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // One clock: drive inputs, check grants, then check the registered outputs after the edge.
    task automatic step(input bit rs, input bit v0, input bit lk, input bit v1,
                        input logic [BW-1:0] b0, input logic [BW-1:0] b1);
        bit    e0, e1, locked, ev0, ev1;
        item_t it;
        rst = rs; r0_valid = v0; r0_lock = lk; r1_valid = v1;
        r0_block = b0; r1_block = b1;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (rs) begin
            locked = prev0 && lk && v0 && (streak < int'(LOCK_MAX));
            if (v0 && v1) e0 = locked || (last_win != 0);
            else          e0 = v0;
            e1 = v1 && !e0;
        end
        check("r0_ready", BW'(r0_ready), BW'(e0));
        check("r1_ready", BW'(r1_ready), BW'(e1));
        check("one_ready", BW'(r0_ready & r1_ready), BW'(0));
        obs_g0 = r0_ready; obs_g1 = r1_ready;
        @(posedge clk);
        #1;
        if (!rs) begin
            sb.delete();
            last_win = -1; prev0 = 1'b0; streak = 0;
            hold0 = '0; hold1 = '0;
        end else begin
            if (e0) begin it.who = 1'b0; it.blk = b0; it.due = cyc + 1; sb.push_back(it); end
            if (e1) begin it.who = 1'b1; it.blk = b1; it.due = cyc + 1; sb.push_back(it); end
            if (e0 && prev0 && lk) streak = (streak < int'(LOCK_MAX)) ? streak + 1 : streak;
            else                   streak = 0;
            if (e0)      last_win = 0;
            else if (e1) last_win = 1;
            prev0 = e0;
        end
        ev0 = 1'b0; ev1 = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            if (it.who) begin ev1 = 1'b1; hold1 = sub_block(it.blk); end
            else        begin ev0 = 1'b1; hold0 = sub_block(it.blk); end
        end
        check("r0_o_valid", BW'(r0_o_valid), BW'(ev0));
        check("r0_o_block", r0_o_block, hold0);
        check("r1_o_valid", BW'(r1_o_valid), BW'(ev1));
        check("r1_o_block", r1_o_block, hold1);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [BW-1:0] all00, all63, all53, all01, allED, all7C;
        all00 = '0;
        all63 = {16{8'h63}};
        all53 = {16{8'h53}};
        all01 = {16{8'h01}};
        allED = {16{8'hed}};
        all7C = {16{8'h7c}};
        for (int k = 0; k < 256; k++) sref[k] = sbox_math(8'(k));
        last_win = -1; prev0 = 1'b0; streak = 0; hold0 = '0; hold1 = '0;

        // Reset state
        do_reset();
        check("rst_o0", r0_o_block, all00);
        check("rst_o1", r1_o_block, all00);

        // Single r0 block of zeros
        step(1'b1, 1'b1, 1'b0, 1'b0, all00, all00);
        idle(1);
        check("zero_v0", BW'(r0_o_valid), BW'(1));
        check("zero_blk", r0_o_block, all63);
        check("zero_v1", BW'(r1_o_valid), BW'(0));
        idle(2);

        // Round-robin alternation, no lock
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, all53, all01);
            check("rr_g0", BW'(obs_g0), BW'(i % 2 == 0));
            if (i >= 1) begin
                check("rr_ov0", BW'(r0_o_valid), BW'((i - 1) % 2 == 0));
                check("rr_blk", ((i - 1) % 2 == 0) ? r0_o_block : r1_o_block,
                      ((i - 1) % 2 == 0) ? allED : all7C);
            end
        end
        idle(3);

        // Lock burst: one initial grant, LOCK_MAX locked grants, one r1 grant, repeat
        do_reset();
        for (int i = 0; i < 36; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, rand_block(), rand_block());
            check("lock_g1", BW'(obs_g1), BW'(i % 12 == 11));
        end
        idle(3);

        // Reset one cycle after an accept discards the block
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_block(), all00);
        step(1'b0, 1'b0, 1'b0, 1'b0, all00, all00);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("flush_v0", BW'(r0_o_valid), BW'(0));
            check("flush_b0", r0_o_block, all00);
        end

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 499) != 0, ($urandom % 4) != 0, ($urandom % 8) != 0,
                 ($urandom % 2) != 0, rand_block(), rand_block());
        end
        idle(4);
        check("drained", BW'(sb.size()), BW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
